// File: rtl/csr_unit_if.sv
// CSR access bus between the execute stage (master) and the CSR file (slave).
interface csr_unit_if;
    logic        csr_en;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_wr_suppress;
    logic [31:0] csr_rdata;
    logic        csr_illegal;

    modport master (
        output csr_en, csr_op, csr_addr, csr_wdata, csr_wr_suppress,
        input  csr_rdata, csr_illegal
    );

    modport slave (
        input  csr_en, csr_op, csr_addr, csr_wdata, csr_wr_suppress,
        output csr_rdata, csr_illegal
    );
endinterface

// File: rtl/csr_unit.sv
// Machine-mode CSR file: trap state, 64-bit cycle/instret counters,
// trap entry / mret sequencing and fetch redirect target.
module csr_unit #(
    parameter logic [31:0] HART_ID  = 32'd0,
    parameter logic [31:0] MISA_VAL = 32'h40000100
) (
    input  logic              clk,
    input  logic              rst,
    csr_unit_if.slave         bus,
    input  logic              instr_retire,
    input  logic              trap_req,
    input  logic [31:0]       trap_cause,
    input  logic [31:0]       trap_pc,
    input  logic              mret,
    output logic [31:0]       redirect_pc,
    output logic              mstatus_mie
);

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RW   = 2'b01,
        OP_RS   = 2'b10,
        OP_RC   = 2'b11
    } csr_op_e;

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MISA     = 12'h301;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;
    localparam logic [11:0] A_MINSTRETH= 12'hB82;
    localparam logic [11:0] A_CYCLE    = 12'hC00;
    localparam logic [11:0] A_INSTRET  = 12'hC02;
    localparam logic [11:0] A_CYCLEH   = 12'hC80;
    localparam logic [11:0] A_INSTRETH = 12'hC82;
    localparam logic [11:0] A_MHARTID  = 12'hF14;

    logic        mie;
    logic        mpie;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mscratch;
    logic [63:0] mcycle;
    logic [63:0] minstret;

    csr_op_e     op;
    logic        known;
    logic [31:0] rd_val;
    logic [31:0] wval;
    logic        write_attempt;
    logic        illegal;
    logic        do_write;

    logic        we_mstatus;
    logic        we_mtvec;
    logic        we_mscratch;
    logic        we_mepc;
    logic        we_mcause;
    logic        we_mcycle;
    logic        we_mcycleh;
    logic        we_minstret;
    logic        we_minstreth;

    logic [63:0] mcycle_nxt;
    logic [63:0] minstret_nxt;
    logic [31:0] mstatus_val;
    logic [31:0] tvec_base;

    assign op          = csr_op_e'(bus.csr_op);
    assign mstatus_val = {19'd0, 2'b11, 3'd0, mpie, 3'd0, mie, 3'd0};
    assign mstatus_mie = mie;

    // Read mux; unknown addresses flag themselves through `known`.
    always_comb begin
        known  = 1'b1;
        rd_val = '0;
        case (bus.csr_addr)
            A_MSTATUS:              rd_val = mstatus_val;
            A_MISA:                 rd_val = MISA_VAL;
            A_MTVEC:                rd_val = mtvec;
            A_MSCRATCH:             rd_val = mscratch;
            A_MEPC:                 rd_val = mepc;
            A_MCAUSE:               rd_val = mcause;
            A_MCYCLE,   A_CYCLE:    rd_val = mcycle[31:0];
            A_MCYCLEH,  A_CYCLEH:   rd_val = mcycle[63:32];
            A_MINSTRET, A_INSTRET:  rd_val = minstret[31:0];
            A_MINSTRETH,A_INSTRETH: rd_val = minstret[63:32];
            A_MHARTID:              rd_val = HART_ID;
            default:                known  = 1'b0;
        endcase
    end

    assign write_attempt = bus.csr_en && (op != OP_NONE) &&
                           !(((op == OP_RS) || (op == OP_RC)) && bus.csr_wr_suppress);
    assign illegal       = bus.csr_en &&
                           (!known || (write_attempt && (bus.csr_addr[11:10] == 2'b11)));
    assign do_write      = write_attempt && !illegal && !trap_req && !mret;

    assign bus.csr_illegal = illegal;
    assign bus.csr_rdata   = illegal ? '0 : rd_val;

    always_comb begin
        wval = rd_val;
        case (op)
            OP_RW:   wval = bus.csr_wdata;
            OP_RS:   wval = rd_val | bus.csr_wdata;
            OP_RC:   wval = rd_val & ~bus.csr_wdata;
            default: wval = rd_val;
        endcase
    end

    always_comb begin
        we_mstatus   = 1'b0;
        we_mtvec     = 1'b0;
        we_mscratch  = 1'b0;
        we_mepc      = 1'b0;
        we_mcause    = 1'b0;
        we_mcycle    = 1'b0;
        we_mcycleh   = 1'b0;
        we_minstret  = 1'b0;
        we_minstreth = 1'b0;
        if (do_write) begin
            case (bus.csr_addr)
                A_MSTATUS:   we_mstatus   = 1'b1;
                A_MTVEC:     we_mtvec     = 1'b1;
                A_MSCRATCH:  we_mscratch  = 1'b1;
                A_MEPC:      we_mepc      = 1'b1;
                A_MCAUSE:    we_mcause    = 1'b1;
                A_MCYCLE:    we_mcycle    = 1'b1;
                A_MCYCLEH:   we_mcycleh   = 1'b1;
                A_MINSTRET:  we_minstret  = 1'b1;
                A_MINSTRETH: we_minstreth = 1'b1;
                default: ;
            endcase
        end
    end

    // A write to either counter half replaces that half and skips the increment.
    always_comb begin
        mcycle_nxt = mcycle + 64'd1;
        if (we_mcycle)
            mcycle_nxt = {mcycle[63:32], wval};
        else if (we_mcycleh)
            mcycle_nxt = {wval, mcycle[31:0]};

        minstret_nxt = instr_retire ? (minstret + 64'd1) : minstret;
        if (we_minstret)
            minstret_nxt = {minstret[63:32], wval};
        else if (we_minstreth)
            minstret_nxt = {wval, minstret[31:0]};
    end

    assign tvec_base = mtvec & ~32'h3;

    always_comb begin
        redirect_pc = mepc;
        if (trap_req) begin
            if (mtvec[0] && trap_cause[31])
                redirect_pc = tvec_base + (trap_cause << 2);
            else
                redirect_pc = tvec_base;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie      <= 1'b0;
            mpie     <= 1'b0;
            mepc     <= '0;
            mcause   <= '0;
        end else if (trap_req) begin
            mpie     <= mie;
            mie      <= 1'b0;
            mepc     <= trap_pc & ~32'h3;
            mcause   <= trap_cause;
        end else if (mret) begin
            mie      <= mpie;
            mpie     <= 1'b1;
        end else begin
            if (we_mstatus) begin
                mie  <= wval[3];
                mpie <= wval[7];
            end
            if (we_mepc)
                mepc <= wval & ~32'h3;
            if (we_mcause)
                mcause <= wval;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtvec    <= '0;
            mscratch <= '0;
        end else begin
            if (we_mtvec)
                mtvec <= wval & ~32'h2;
            if (we_mscratch)
                mscratch <= wval;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            mcycle   <= mcycle_nxt;
            minstret <= minstret_nxt;
        end
    end

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: expected results queued per step, checked on the falling edge.
module tb_csr_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_retire;
    logic        trap_req;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic        mret;
    logic [31:0] redirect_pc;
    logic        mstatus_mie;

    csr_unit_if bus ();

    csr_unit #(.HART_ID(32'd0), .MISA_VAL(32'h40000100)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .instr_retire (instr_retire),
        .trap_req     (trap_req),
        .trap_cause   (trap_cause),
        .trap_pc      (trap_pc),
        .mret         (mret),
        .redirect_pc  (redirect_pc),
        .mstatus_mie  (mstatus_mie)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        illegal;
        logic        mie;
        logic        chk_redir;
        logic [31:0] redir;
    } exp_t;

    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    logic        p_trap   = 1'b0;
    logic [31:0] p_cause  = '0;
    logic [31:0] p_pc     = '0;
    logic        p_mret   = 1'b0;
    logic        p_retire = 1'b0;

    localparam logic [1:0] RW = 2'b01, RS = 2'b10, RC = 2'b11;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [1:0] op, input logic [11:0] addr,
                        input logic [31:0] wdata, input logic sup,
                        input logic [31:0] exp_rd, input logic exp_ill, input logic exp_mie,
                        input logic chk_redir = 1'b0, input logic [31:0] exp_redir = '0);
        exp_t e;
        @(posedge clk);
        #1;
        bus.csr_en          = 1'b1;
        bus.csr_op          = op;
        bus.csr_addr        = addr;
        bus.csr_wdata       = wdata;
        bus.csr_wr_suppress = sup;
        trap_req            = p_trap;
        trap_cause          = p_cause;
        trap_pc             = p_pc;
        mret                = p_mret;
        instr_retire        = p_retire;
        p_trap = 1'b0; p_mret = 1'b0; p_retire = 1'b0;
        e.tag = tag; e.rdata = exp_rd; e.illegal = exp_ill; e.mie = exp_mie;
        e.chk_redir = chk_redir; e.redir = exp_redir;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        check({e.tag, ".rdata"}, bus.csr_rdata, e.rdata);
        check({e.tag, ".illegal"}, {31'd0, bus.csr_illegal}, {31'd0, e.illegal});
        check({e.tag, ".mie"}, {31'd0, mstatus_mie}, {31'd0, e.mie});
        if (e.chk_redir)
            check({e.tag, ".redirect"}, redirect_pc, e.redir);
    endtask

    // Plain read: RS with suppressed write.
    task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp_rd,
                      input logic exp_mie, input logic chk_redir = 1'b0,
                      input logic [31:0] exp_redir = '0);
        step(tag, RS, addr, 32'd0, 1'b1, exp_rd, 1'b0, exp_mie, chk_redir, exp_redir);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.csr_en = 1'b0; bus.csr_op = 2'b00; bus.csr_addr = '0;
        bus.csr_wdata = '0; bus.csr_wr_suppress = 1'b0;
        instr_retire = 1'b0; trap_req = 1'b0; trap_cause = '0; trap_pc = '0; mret = 1'b0;
        repeat (2) @(posedge clk);

        rd("rst_mscratch", 12'h340, 32'h0, 1'b0, 1'b1, 32'h0);
        rst = 1'b0;

        // Reset values and identity registers
        rd("mstatus_rst", 12'h300, 32'h00001800, 1'b0);
        rd("misa",        12'h301, 32'h40000100, 1'b0);
        rd("mhartid",     12'hF14, 32'h00000000, 1'b0);

        // RW / RS / RC on mscratch
        step("rw_scratch", RW, 12'h340, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1'b0);
        step("rs_scratch", RS, 12'h340, 32'h0000000F, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
        step("rc_scratch", RC, 12'h340, 32'hDEAD0000, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
        rd("scratch_rc", 12'h340, 32'h0000BEEF, 1'b0);
        step("rs_supp",    RS, 12'h340, 32'hFFFFFFFF, 1'b1, 32'h0000BEEF, 1'b0, 1'b0);
        rd("scratch_supp", 12'h340, 32'h0000BEEF, 1'b0);

        // Counter wrap: step n after reset release sees mcycle == n
        step("wr_mcycleh", RW, 12'hB80, 32'hFFFFFFFF, 1'b0, 32'h0,  1'b0, 1'b0);
        step("wr_mcycle",  RW, 12'hB00, 32'hFFFFFFFE, 1'b0, 32'd10, 1'b0, 1'b0);
        rd("idle0", 12'h340, 32'h0000BEEF, 1'b0);
        rd("idle1", 12'h340, 32'h0000BEEF, 1'b0);
        rd("mcycle_wrap",   12'hB00, 32'h0, 1'b0);
        rd("mcycleh_wrap",  12'hB80, 32'h0, 1'b0);
        rd("minstret_hold", 12'hB02, 32'h0, 1'b0);
        rd("minstreth_hold",12'hB82, 32'h0, 1'b0);

        // Illegal accesses
        step("rw_cycle_ill", RW, 12'hC00, 32'h00000055, 1'b0, 32'h0, 1'b1, 1'b0);
        step("rw_7c0_ill",   RW, 12'h7C0, 32'h00000055, 1'b0, 32'h0, 1'b1, 1'b0);
        step("rs_cycle_ro",  RS, 12'hC00, 32'hFFFFFFFF, 1'b1, 32'd6, 1'b0, 1'b0);
        rd("cycleh", 12'hC80, 32'h0, 1'b0);
        step("rw_hartid_ill", RW, 12'hF14, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0);
        step("rw_misa",       RW, 12'h301, 32'h0, 1'b0, 32'h40000100, 1'b0, 1'b0);
        rd("misa_kept", 12'h301, 32'h40000100, 1'b0);

        // instret counting
        p_retire = 1'b1; rd("instret0", 12'hC02, 32'd0, 1'b0);
        p_retire = 1'b1; rd("instret1", 12'hC02, 32'd1, 1'b0);
        rd("instret2", 12'hC02, 32'd2, 1'b0);
        rd("instret3", 12'hC02, 32'd2, 1'b0);

        // Vectored trap entry and mret
        step("wr_mtvec",   RW, 12'h305, 32'h00000103, 1'b0, 32'h0,        1'b0, 1'b0);
        step("wr_mstatus", RW, 12'h300, 32'h00000008, 1'b0, 32'h00001800, 1'b0, 1'b0);
        rd("mtvec_warl", 12'h305, 32'h00000101, 1'b1);
        p_trap = 1'b1; p_cause = 32'h80000007; p_pc = 32'h00000046;
        rd("trap_vec", 12'h300, 32'h00001808, 1'b1, 1'b1, 32'h0000011C);
        rd("mepc_trap", 12'h341, 32'h00000044, 1'b0, 1'b1, 32'h00000044);
        rd("mstatus_trap", 12'h300, 32'h00001880, 1'b0);
        rd("mcause_trap", 12'h342, 32'h80000007, 1'b0);
        p_mret = 1'b1;
        rd("mret", 12'h300, 32'h00001880, 1'b0, 1'b1, 32'h00000044);
        rd("mstatus_mret", 12'h300, 32'h00001888, 1'b1, 1'b1, 32'h00000044);
        p_mret = 1'b1;
        step("mret_drop_wr", RW, 12'h340, 32'h00001111, 1'b0, 32'h0000BEEF, 1'b0, 1'b1);
        rd("scratch_mret", 12'h340, 32'h0000BEEF, 1'b1);

        // Trap beats a simultaneous CSR write; non-interrupt cause uses BASE
        p_trap = 1'b1; p_cause = 32'h00000002; p_pc = 32'h00000200;
        step("trap_drop_wr", RW, 12'h340, 32'h12345678, 1'b0, 32'h0000BEEF, 1'b0, 1'b1,
             1'b1, 32'h00000100);
        rd("scratch_trap", 12'h340, 32'h0000BEEF, 1'b0);
        rd("mcause_2", 12'h342, 32'h00000002, 1'b0, 1'b1, 32'h00000200);

        // Reset asserted while a write is on the bus
        @(posedge clk);
        #1;
        bus.csr_op = RW; bus.csr_addr = 12'h340; bus.csr_wdata = 32'h0000CAFE;
        bus.csr_wr_suppress = 1'b0; trap_req = 1'b0; mret = 1'b0;
        #1 rst = 1'b1;
        bus.csr_op = RS; bus.csr_wr_suppress = 1'b1; bus.csr_wdata = '0;
        #1 rst = 1'b0;
        rd("scratch_rst", 12'h340, 32'h0, 1'b0);
        rd("mepc_rst",    12'h341, 32'h0, 1'b0, 1'b1, 32'h0);
        rd("mcause_rst",  12'h342, 32'h0, 1'b0);
        rd("mtvec_rst",   12'h305, 32'h0, 1'b0);
        rd("mstatus_rst2",12'h300, 32'h00001800, 1'b0);
        rd("mcycle_rst",  12'hB00, 32'd6, 1'b0);
        rd("mcycleh_rst", 12'hB80, 32'h0, 1'b0);
        rd("minstret_rst",12'hB02, 32'h0, 1'b0);

        // Direct (MODE=0) trap ignores the interrupt cause
        step("wr_mtvec_dir", RW, 12'h305, 32'h00000200, 1'b0, 32'h0, 1'b0, 1'b0);
        p_trap = 1'b1; p_cause = 32'h80000005; p_pc = 32'h00000080;
        rd("trap_direct", 12'h300, 32'h00001800, 1'b0, 1'b1, 32'h00000200);
        rd("mepc_direct", 12'h341, 32'h00000080, 1'b0);

        @(posedge clk);
        #1 bus.csr_en = 1'b0; trap_req = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
- Machine-mode CSR file for the RV32i core: the responder to the CSRRW/CSRRS/CSRRC(+I) accesses issued by the execute stage.
- Holds trap state (mstatus, mtvec, mepc, mcause, mscratch) and the 64-bit cycle/instret counters.
- Sequences trap entry and mret, and supplies the redirect PC to the fetch unit.
- Reads are combinational; all state updates occur on the rising clock edge.

Parameters:
- HART_ID, 0, value returned by mhartid (0xF14).
- MISA_VAL, 32'h40000100, value returned by misa (0x301): RV32I.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- csr_en  in  1  CSR instruction valid this cycle
- csr_op  in  2  01 RW, 10 RS (set), 11 RC (clear), 00 no-op
- csr_addr  in  12  CSR address
- csr_wdata  in  32  rs1 value or zero-extended zimm
- csr_wr_suppress  in  1  rs1/zimm field is 0 on RS/RC: read-only access
- csr_rdata  out  32  current (pre-write) CSR value, combinational
- csr_illegal  out  1  access illegal, combinational
- instr_retire  in  1  one instruction retired this cycle
- trap_req  in  1  take exception/interrupt this cycle
- trap_cause  in  32  mcause value to record
- trap_pc  in  32  PC of the faulting instruction
- mret  in  1  mret executing this cycle
- redirect_pc  out  32  trap target when trap_req, else mepc (combinational)
- mstatus_mie  out  1  global interrupt enable

Behaviour:
- Reset (async, rst=1): mstatus.MIE=0, MPIE=0; mtvec=0, mepc=0, mcause=0, mscratch=0; mcycle=0, minstret=0; csr_rdata=0 only if addressed CSR is 0.
- Implemented CSRs:
  - mstatus 0x300: MIE bit3, MPIE bit7, MPP bits12:11 hardwired 11, all other bits read 0.
  - misa 0x301 (read-only, writes ignored but legal).
  - mtvec 0x305: bit1 forced 0 (WARL).
  - mscratch 0x340.
  - mepc 0x341: bits1:0 forced 0.
  - mcause 0x342.
  - mcycle/mcycleh 0xB00/0xB80; minstret/minstreth 0xB02/0xB82.
  - Read-only mirrors: cycle 0xC00, cycleh 0xC80, instret 0xC02, instreth 0xC82; mhartid 0xF14.
- Write value:
  - RW: wdata.
  - RS: old | wdata.
  - RC: old & ~wdata.
  - A write occurs when csr_en & op!=00 & !(op in {RS,RC} & csr_wr_suppress) & !csr_illegal.
- Illegal access: unknown address, or write attempt to addr[11:10]==11.
  - csr_illegal=1, csr_rdata=0, no state change.
  - The core raises the trap itself on a later cycle.
- Counters:
  - mcycle += 1 every cycle.
  - minstret += 1 when instr_retire.
  - Both are 64-bit and wrap to 0 after 2^64-1.
  - A CSR write to either half replaces that half with the written value in that cycle; that counter's increment is suppressed that cycle. The other half holds.
- Trap entry (trap_req=1):
  - mepc<=trap_pc&~3, mcause<=trap_cause, MPIE<=MIE, MIE<=0.
  - redirect_pc: mtvec.MODE=0 gives BASE (mtvec&~3). MODE=1 with cause[31]=1 gives BASE+4*cause[30:0]. MODE=1 with cause[31]=0 gives BASE.
- mret (mret=1, trap_req=0): MIE<=MPIE, MPIE<=1; redirect_pc=mepc.
- Priority in one cycle: trap_req > mret > CSR write.
  - A CSR write in the same cycle as trap_req or mret is dropped.
  - csr_rdata is still driven.
- Counter increments are independent of trap/mret.
- Reset asserted mid-operation clears state immediately; no partial writes survive.

Test Plan:
- Reset release, read 0x300, 0x301, 0xF14 -> 0x00001800, 0x40000100, 0x00000000; csr_illegal=0.
- RW mscratch 0xDEADBEEF, next cycle RS 0x0000000F then RC 0xDEAD0000 -> reads 0xDEADBEEF, 0xDEADBEEF, 0x0000BEEF; RS with csr_wr_suppress=1 and wdata=0xFFFFFFFF leaves 0x0000BEEF.
- RW to 0xC00 or to unimplemented 0x7C0 -> csr_illegal=1, csr_rdata=0, no counter/state change; RS to 0xC00 with csr_wr_suppress=1 -> legal read of cycle.
- RW mcycleh=0xFFFFFFFF, RW mcycle=0xFFFFFFFE, then idle 2 cycles -> mcycle/mcycleh read 0x00000000/0x00000000 (wrap); minstret unchanged without instr_retire.
- mtvec=0x00000101, MIE=1; trap_req with cause 0x80000007, trap_pc 0x00000046 -> redirect_pc 0x0000011C; mepc 0x44; MIE=0, MPIE=1. Then mret -> redirect_pc 0x44; MIE=1, MPIE=1.
- trap_req, cause 2, with simultaneous RW mscratch 0x12345678 -> mscratch unchanged, mcause=2; assert rst mid-sequence -> all registers at reset values on next read.
